ffbank_arbiter: RTL and testbench
=================================

FFBANK_ARBITER -- requirements
Module: ffbank_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, flip-flop bank width in bits.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester request, level.
REQ-006 SHALL have port op  input  2*NUM_REQ  per-requester opcode: 00 HOLD, 01 LOAD, 10 TOGGLE, 11 CLEAR.
REQ-007 SHALL have port data  input  WIDTH*NUM_REQ  per-requester operand.
REQ-008 SHALL have port gnt  output  NUM_REQ  one-hot grant, registered.
REQ-009 SHALL have port ack  output  NUM_REQ  one-hot completion pulse, registered.
REQ-010 SHALL have port q  output  WIDTH  bank state.
REQ-011 SHALL have port qbar  output  WIDTH  bitwise complement of q.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, COMMIT, ACK.
REQ-014 IDLE: any req high -> GRANT next cycle; none -> stay IDLE.
REQ-015 GRANT: gnt bit of winner high exactly this one cycle; op/data of winner latched at end of cycle -> COMMIT.
REQ-016 COMMIT: bank written at end of cycle per latched op -> ACK.
REQ-017 ACK: ack bit of winner high exactly this one cycle, q already shows new value; any req high excluding last winner -> GRANT, else IDLE.
REQ-018 Latency: req seen in IDLE cycle N -> gnt in N+1 -> q updated and ack in N+3.
REQ-019 Requester SHALL hold req, op, data stable until gnt; deasserts req no later than the cycle after ack.
REQ-020 Requester dropping req during GRANT SHALL NOT abort; latched op completes and ack still issues.
REQ-021 Arbitration SHALL be round-robin: search starts at index after last winner, wraps NUM_REQ-1 -> 0; reset pointer gives index 0 highest priority.
REQ-022 LOAD: q <= data (D behaviour).
REQ-023 TOGGLE: each bit with data bit 1 inverts, others hold (T behaviour).
REQ-024 CLEAR: q <= 0; HOLD: q unchanged, ack still issued.
REQ-025 qbar SHALL equal ~q at all times, including reset.
REQ-026 gnt and ack SHALL never have more than one bit set and SHALL never be high together.

Reset
REQ-027 rstn low SHALL force immediately: state IDLE, q 0, qbar all ones, gnt 0, ack 0, busy 0, pointer 0, latched op HOLD.
REQ-028 Reset mid-operation SHALL discard the in-flight op without ack; first post-reset grant follows REQ-014.

Configuration
REQ-029 Macro FFBANK_PARITY_EN defined: extra output parity (1 bit) = registered XOR of q, reset 0, valid in the same cycle as the new q.
REQ-030 FFBANK_PARITY_EN undefined: parity port and logic absent; all other behaviour identical.

Structure
REQ-031 Package ffbank_pkg SHALL hold the opcode enum (HOLD, LOAD, TOGGLE, CLEAR) and the FSM state typedef.
REQ-032 Sub-module ffbank_cell SHALL implement one bank bit: async active-low reset, enable, mode D/T/clear, outputs q and qbar; instantiated WIDTH times.

Verification
REQ-033 Reset release, req=0001, op0=LOAD, data0=0xA5 -> gnt=0001 one cycle later, q=0xA5, qbar=0x5A with ack=0001 two cycles after gnt.
REQ-034 q=0xA5, req=0010, op1=TOGGLE, data1=0x0F -> q=0xAA, ack=0010.
REQ-035 All four req high from reset -> grant order 0,1,2,3,0; each ack precedes next gnt; no gnt/ack overlap.
REQ-036 op=CLEAR from q=0xFF -> q=0x00, qbar=0xFF; op=HOLD -> q unchanged, ack still pulses.
REQ-037 rstn low during COMMIT of LOAD 0x3C -> q=0, no ack, busy=0; after release pending req re-granted per round-robin from index 0.
REQ-038 With FFBANK_PARITY_EN, LOAD 0x07 -> parity=1 in ack cycle; LOAD 0x03 -> parity=0.

Source files
------------

// File: rtl/ffbank_pkg.sv
// Shared types for the flip-flop bank arbiter: opcodes, FSM states and the
// per-bit next-state rule used by every bank cell.
package ffbank_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        LOAD   = 2'b01,
        TOGGLE = 2'b10,
        CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT  = 2'b01,
        COMMIT = 2'b10,
        ACK    = 2'b11
    } state_e;

    // Next value of one bank bit: D for LOAD, T for TOGGLE, 0 for CLEAR.
    function automatic logic cell_next(input op_e mode, input logic q, input logic d);
        logic n;
        case (mode)
            LOAD:    n = d;
            TOGGLE:  n = q ^ d;
            CLEAR:   n = 1'b0;
            default: n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ffbank_cell.sv
// One bank bit: enabled D/T/clear flip-flop with complementary outputs.
module ffbank_cell
    import ffbank_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  op_e  mode,
    input  logic d,
    output logic q,
    output logic qbar
);

    logic r_q;

    // Bit state: cleared on reset, updated only while enabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_q <= 1'b0;
        else if (en)
            r_q <= cell_next(mode, r_q, d);
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule

// File: rtl/ffbank_arbiter.sv
// Round-robin arbiter granting requesters one at a time write access to a
// shared flip-flop bank. Sequence per op: GRANT -> COMMIT (bank write) -> ACK.
// Optional parity output enabled by defining FFBANK_PARITY_EN.
module ffbank_arbiter
    import ffbank_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     op,
    input  logic [WIDTH*NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         qbar,
    output logic                     busy
`ifdef FFBANK_PARITY_EN
    ,
    output logic                     parity
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_e             r_state, w_state_nxt;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_win;
    logic [NUM_REQ-1:0] r_gnt, r_ack;
    op_e                r_op;
    logic [WIDTH-1:0]   r_data;

    logic               w_sel_vld;
    logic [IW-1:0]      w_sel;
    logic               w_ld_gnt, w_ld_ack;
    logic               w_commit;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return IW'(s);
    endfunction

    // Round-robin pick starting at the pointer; in ACK the finishing winner
    // is skipped so a requester still holding req cannot win twice in a row.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_sel_vld && req[rr_idx(r_ptr, k)] &&
                !(r_state == ACK && rr_idx(r_ptr, k) == r_win)) begin
                w_sel_vld = 1'b1;
                w_sel     = rr_idx(r_ptr, k);
            end
        end
    end

    // FSM next state and one-cycle load strobes for grant/ack.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_gnt    = 1'b0;
        w_ld_ack    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_vld) begin
                    w_state_nxt = GRANT;
                    w_ld_gnt    = 1'b1;
                end
            end
            GRANT:  w_state_nxt = COMMIT;
            COMMIT: begin
                w_state_nxt = ACK;
                w_ld_ack    = 1'b1;
            end
            ACK: begin
                if (w_sel_vld) begin
                    w_state_nxt = GRANT;
                    w_ld_gnt    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Grant/ack pulses, winner index and round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gnt <= '0;
            r_ack <= '0;
            r_win <= '0;
            r_ptr <= '0;
        end else begin
            r_gnt <= w_ld_gnt ? (ONE << w_sel) : '0;
            r_ack <= w_ld_ack ? (ONE << r_win) : '0;
            if (w_ld_gnt) begin
                r_win <= w_sel;
                r_ptr <= (w_sel == IW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

    // Capture the winner's op/data at the end of GRANT; requester may
    // change or drop them afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op   <= HOLD;
            r_data <= '0;
        end else if (r_state == GRANT) begin
            r_op   <= op_e'(op[int'(r_win)*2 +: 2]);
            r_data <= data[int'(r_win)*WIDTH +: WIDTH];
        end
    end

    assign w_commit = (r_state == COMMIT);

    generate
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            ffbank_cell u_cell (
                .clk  (clk),
                .rstn (rstn),
                .en   (w_commit),
                .mode (r_op),
                .d    (r_data[b]),
                .q    (q[b]),
                .qbar (qbar[b])
            );
        end
    endgenerate

`ifdef FFBANK_PARITY_EN
    logic r_parity;

    // Parity of the value being written, so it lands with the new q:
    // XOR of a toggled vector is XOR(q) ^ XOR(mask).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_parity <= 1'b0;
        else if (w_commit) begin
            case (r_op)
                LOAD:    r_parity <= ^r_data;
                TOGGLE:  r_parity <= (^q) ^ (^r_data);
                CLEAR:   r_parity <= 1'b0;
                default: r_parity <= ^q;
            endcase
        end
    end

    assign parity = r_parity;
`endif

    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_ffbank_arbiter.sv
// Self-checking bench for ffbank_arbiter: directed scenarios plus randomized
// request traffic checked against a transaction-level model.
module tb_ffbank_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] data;
    logic [3:0]  gnt, ack;
    logic [7:0]  q, qbar;
    logic        busy;
`ifdef FFBANK_PARITY_EN
    logic        parity;
`endif

    ffbank_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .req  (req),
        .op   (op),
        .data (data),
        .gnt  (gnt),
        .ack  (ack),
        .q    (q),
        .qbar (qbar),
        .busy (busy)
`ifdef FFBANK_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: bank value, pending requesters, round-robin start index.
    logic [7:0] m_q;
    logic [3:0] m_pend;
    int         m_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [1:0] o, input logic [7:0] cur, input logic [7:0] d);
        case (o)
            2'b01:   return d;
            2'b10:   return cur ^ d;
            2'b11:   return 8'h00;
            default: return cur;
        endcase
    endfunction

    function automatic int model_winner();
        for (int k = 0; k < 4; k++)
            if (m_pend[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] d);
        op[2*i +: 2]   = o;
        data[8*i +: 8] = d;
        req[i]         = 1'b1;
        m_pend[i]      = 1'b1;
    endtask

    task automatic raise_random(input int excl);
        for (int i = 0; i < 4; i++)
            if (!m_pend[i] && i != excl && $urandom_range(1, 0) == 1)
                set_req(i, 2'($urandom), 8'($urandom));
        if (m_pend == 4'b0000)
            set_req((excl + 1) % 4, 2'($urandom), 8'($urandom));
    endtask

    // Serve the model's next winner: check grant cycle, commit cycle, ack cycle.
    // Returns at the ack-cycle negedge with the winner's req dropped.
    task automatic serve_one(output int w);
        int         cyc;
        logic [1:0] o;
        logic [7:0] d, exp_q, exp_qb;
        w   = model_winner();
        o   = op[2*w +: 2];
        d   = data[8*w +: 8];
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (gnt == 4'b0000 && cyc < 8);
        check("gnt_latency", cyc, 1);
        check("gnt_onehot", gnt, 32'(1) << w);
        check("ack_in_grant", ack, 0);
        check("busy_grant", busy, 1);
        m_ptr = (w + 1) % 4;
        if ($urandom_range(1, 0) == 1) begin
            req[w]    = 1'b0;
            m_pend[w] = 1'b0;
        end
        @(negedge clk);
        check("gnt_commit", gnt, 0);
        check("ack_commit", ack, 0);
        check("q_commit", q, m_q);
        op[2*w +: 2]   = 2'($urandom);
        data[8*w +: 8] = 8'($urandom);
        exp_q  = model_next(o, m_q, d);
        exp_qb = ~exp_q;
        @(negedge clk);
        check("ack_onehot", ack, 32'(1) << w);
        check("gnt_in_ack", gnt, 0);
        check("q_ack", q, exp_q);
        check("qbar_ack", qbar, exp_qb);
`ifdef FFBANK_PARITY_EN
        check("parity_ack", parity, ^exp_q);
`endif
        m_q       = exp_q;
        req[w]    = 1'b0;
        m_pend[w] = 1'b0;
    endtask

    task automatic reset_model();
        m_q    = 8'h00;
        m_ptr  = 0;
        m_pend = req;
    endtask

    // Continuous invariants: one-hot grant/ack, never together, qbar = ~q.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            check("gnt_max1", $countones(gnt) <= 1, 1);
            check("ack_max1", $countones(ack) <= 1, 1);
            check("gnt_ack_excl", |(gnt & {4{|ack}}) | (|gnt & |ack), 0);
            check("qbar_inv", qbar, {24'h0, ~q});
        end
    end

    initial begin
        int w;
        int last;
        req  = 4'b0000;
        op   = 8'h00;
        data = 32'h0;
        rstn = 1'b0;
        reset_model();
        #1;
        check("rst_q", q, 8'h00);
        check("rst_qbar", qbar, 8'hFF);
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
`ifdef FFBANK_PARITY_EN
        check("rst_parity", parity, 0);
`endif
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Release with requester 0 LOAD A5, then requester 1 TOGGLE 0F.
        rstn = 1'b1;
        set_req(0, 2'b01, 8'hA5);
        serve_one(w);
        check("load_a5", q, 8'hA5);
        set_req(1, 2'b10, 8'h0F);
        serve_one(w);
        check("toggle_aa", q, 8'hAA);

        // CLEAR from FF, then HOLD leaves q but still acks.
        set_req(2, 2'b01, 8'hFF);
        serve_one(w);
        set_req(3, 2'b11, 8'hA5);
        serve_one(w);
        check("clear_q", q, 8'h00);
        check("clear_qbar", qbar, 8'hFF);
        set_req(0, 2'b01, 8'h3C);
        serve_one(w);
        set_req(1, 2'b00, 8'hFF);
        serve_one(w);
        check("hold_q", q, 8'h3C);

`ifdef FFBANK_PARITY_EN
        set_req(2, 2'b01, 8'h07);
        serve_one(w);
        check("parity_07", parity, 1);
        set_req(3, 2'b01, 8'h03);
        serve_one(w);
        check("parity_03", parity, 0);
`endif
        @(negedge clk);
        check("idle_after", busy, 0);

        // All four requesting from reset: order 0,1,2,3 then 0 again.
        rstn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 2'($urandom), 8'($urandom));
        reset_model();
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            serve_one(w);
            check("rr_order", gnt === 4'b0000 && ack === (4'b0001 << (k % 4)), 1);
            if (k == 1) set_req(0, 2'($urandom), 8'($urandom));
        end
        @(negedge clk);
        check("rr_idle", busy, 0);

        // Reset during COMMIT of LOAD 3C discards it; pointer restarts at 0.
        set_req(2, 2'b01, 8'h5A);
        serve_one(w);
        set_req(1, 2'b01, 8'h3C);
        repeat (2) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        set_req(3, 2'b01, 8'hC3);
        rstn = 1'b0;
        #1;
        check("mid_rst_q", q, 8'h00);
        check("mid_rst_qbar", qbar, 8'hFF);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gnt", gnt, 0);
        @(negedge clk);
        check("mid_rst_ack", ack, 0);
        reset_model();
        rstn = 1'b1;
        serve_one(w);
        check("post_rst_q", q, 8'h3C);
        serve_one(w);

        // Randomized traffic.
        last = 0;
        for (int r = 0; r < 40; r++) begin
            raise_random(last);
            serve_one(w);
            last = w;
        end
        while (m_pend != 4'b0000) serve_one(w);
        @(negedge clk);
        check("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
